intra_edge_loader: RTL and testbench



---
 rtl/intra_edge_loader.sv | 126 ++++++++++++
 tb/tb_intra_edge_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/intra_edge_loader.sv
// Assembles the above/left intra neighbour edge from a serial sample stream,
// substitutes missing sides, and holds the result until the predictor takes it.
module intra_edge_loader #(
  parameter int W        = 8,
  parameter int H        = 8,
  parameter int BITDEPTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                have_above,
  input  logic                have_left,
  input  logic                s_valid,
  input  logic [29:0]         s_data,
  output logic                s_ready,
  output logic                edge_valid,
  input  logic                edge_ready,
  output logic [W-1:0][29:0]  above_row,
  output logic [H-1:0][29:0]  left_col,
  output logic                busy
);

  localparam int MAXWH = (W > H) ? W : H;
  localparam int CW    = (MAXWH > 1) ? $clog2(MAXWH) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(W - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H - 1);

  // Mid-grey substitutes when no neighbour exists at all.
  localparam logic [9:0]  MID_LO     = 10'((1 << (BITDEPTH - 1)) - 1);
  localparam logic [9:0]  MID_HI     = 10'((1 << (BITDEPTH - 1)) + 1);
  localparam logic [29:0] FILL_ABOVE = {MID_LO, MID_LO, MID_LO};
  localparam logic [29:0] FILL_LEFT  = {MID_HI, MID_HI, MID_HI};

  typedef enum logic [2:0] {IDLE, LOAD_ABOVE, LOAD_LEFT, FILL, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 have_above_q, have_above_d;
  logic                 have_left_q, have_left_d;
  logic [W-1:0][29:0]   above_q, above_d;
  logic [H-1:0][29:0]   left_q, left_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    have_above_d = have_above_q;
    have_left_d  = have_left_q;
    above_d      = above_q;
    left_d       = left_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          have_above_d = have_above;
          have_left_d  = have_left;
          cnt_d        = '0;
          if (have_above)     state_d = LOAD_ABOVE;
          else if (have_left) state_d = LOAD_LEFT;
          else                state_d = FILL;
        end
      end
      LOAD_ABOVE: begin
        if (s_valid) begin
          above_d[cnt_q] = s_data;
          if (cnt_q == W_LAST) begin
            cnt_d   = '0;
            state_d = have_left_q ? LOAD_LEFT : FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_LEFT: begin
        if (s_valid) begin
          left_d[cnt_q] = s_data;
          if (cnt_q == H_LAST) begin
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        // Whole 30-bit copies substitute all three components identically.
        if (!have_above_q && have_left_q) begin
          for (int i = 0; i < W; i++) above_d[i] = left_q[0];
        end else if (have_above_q && !have_left_q) begin
          for (int i = 0; i < H; i++) left_d[i] = above_q[0];
        end else if (!have_above_q && !have_left_q) begin
          for (int i = 0; i < W; i++) above_d[i] = FILL_ABOVE;
          for (int i = 0; i < H; i++) left_d[i]  = FILL_LEFT;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (edge_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      have_above_q <= 1'b0;
      have_left_q  <= 1'b0;
      above_q      <= '0;
      left_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      have_above_q <= have_above_d;
      have_left_q  <= have_left_d;
      above_q      <= above_d;
      left_q       <= left_d;
    end
  end

  assign s_ready    = (state_q == LOAD_ABOVE) || (state_q == LOAD_LEFT);
  assign edge_valid = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign above_row  = above_q;
  assign left_col   = left_q;

endmodule

// File: tb/tb_intra_edge_loader.sv
// Randomized bench for intra_edge_loader: a queue-based edge model predicts the
// assembled arrays, beat counts and edge_valid timing for each block.
module tb_intra_edge_loader;
  localparam int W = 8;
  localparam int H = 8;
  localparam int BD = 10;

  logic clk = 1'b0;
  logic rst, start, have_above, have_left, s_valid, edge_ready;
  logic [29:0] s_data;
  logic s_ready, edge_valid, busy;
  logic [W-1:0][29:0] above_row;
  logic [H-1:0][29:0] left_col;

  int tests = 0;
  int fails = 0;

  intra_edge_loader #(.W(W), .H(H), .BITDEPTH(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .have_above(have_above), .have_left(have_left),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .edge_valid(edge_valid),
    .edge_ready(edge_ready), .above_row(above_row), .left_col(left_col), .busy(busy)
  );

  always #5 clk = ~clk;

  // pat: 0 random samples, 1 Y ramps 10.. / 20.., 2 random with left[0] = {300,200,100}
  task automatic do_block(input bit ha, input bit hl, input int gap_pct, input int hold_lo,
                          input int pat);
    logic [29:0] strm[$];
    logic [W-1:0][29:0] ea;
    logic [H-1:0][29:0] el;
    logic [29:0] v;
    int na = ha ? W : 0;
    int nl = hl ? H : 0;
    int idx = 0;
    int cyc;
    for (int i = 0; i < na + nl; i++) begin
      v = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
      if (pat == 1) v = (i < na) ? 30'(10 + i) : 30'(20 + i - na);
      if (pat == 2 && i == na) v = {10'd300, 10'd200, 10'd100};
      strm.push_back(v);
    end
    ea = '0;
    el = '0;
    for (int i = 0; i < W; i++) if (ha) ea[i] = strm[i];
    for (int i = 0; i < H; i++) if (hl) el[i] = strm[na + i];
    if (!ha && hl) for (int i = 0; i < W; i++) ea[i] = el[0];
    if (ha && !hl) for (int i = 0; i < H; i++) el[i] = ea[0];
    if (!ha && !hl) begin
      for (int i = 0; i < W; i++) ea[i] = {10'd511, 10'd511, 10'd511};
      for (int i = 0; i < H; i++) el[i] = {10'd513, 10'd513, 10'd513};
    end

    @(negedge clk);
    start = 1'b1; have_above = ha; have_left = hl; s_valid = 1'b0;
    edge_ready = (hold_lo == 0);
    @(negedge clk);
    start = 1'b0; have_above = 1'($urandom); have_left = 1'($urandom);
    cyc = 1;
    while (cyc < 400 && !edge_valid) begin
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_data  = (idx < strm.size()) ? strm[idx] : 30'h3FFF_FFFF;
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b1;
    s_data  = 30'h2AAA_AAAA;

    tests++;
    if (!edge_valid) begin
      fails++;
      $display("FAIL edge_valid_timeout: got %0b after %0d cycles, want 1", edge_valid, cyc);
    end
    tests++;
    if (idx != na + nl) begin
      fails++;
      $display("FAIL beat_count: got %0d beats, want %0d", idx, na + nl);
    end
    if (gap_pct == 0) begin
      tests++;
      if (cyc != na + nl + 2) begin
        fails++;
        $display("FAIL edge_latency: edge_valid in cycle %0d, want %0d", cyc, na + nl + 2);
      end
    end
    tests++;
    if (above_row !== ea) begin
      fails++;
      $display("FAIL above_row: got %h want %h", above_row, ea);
    end
    tests++;
    if (left_col !== el) begin
      fails++;
      $display("FAIL left_col: got %h want %h", left_col, el);
    end

    for (int k = 0; k < hold_lo; k++) begin
      edge_ready = 1'b0;
      start = (k == 2);
      @(negedge clk);
      tests++;
      if (!edge_valid || s_ready || !busy || above_row !== ea || left_col !== el) begin
        fails++;
        $display("FAIL hold_stable: k=%0d ev=%0b rdy=%0b busy=%0b above=%h left=%h",
                 k, edge_valid, s_ready, busy, above_row, left_col);
      end
    end
    start = 1'b0;
    edge_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (edge_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL release: edge_valid=%0b busy=%0b, want 0/0", edge_valid, busy);
    end
    edge_ready = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; have_above = 1'b0; have_left = 1'b0;
    s_valid = 1'b0; s_data = '0; edge_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (s_ready !== 1'b0 || edge_valid !== 1'b0 || busy !== 1'b0 ||
        above_row !== '0 || left_col !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b ev=%0b busy=%0b above=%h left=%h, want all 0",
               s_ready, edge_valid, busy, above_row, left_col);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_midload();
    @(negedge clk);
    start = 1'b1; have_above = 1'b1; have_left = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    repeat (5) begin
      s_data = 30'($urandom) | 30'h1;
      @(negedge clk);
    end
    tests++;
    if (above_row[0] === 30'h0 || !busy) begin
      fails++;
      $display("FAIL midload_progress: above[0]=%h busy=%0b, want nonzero/1", above_row[0], busy);
    end
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || edge_valid !== 1'b0 ||
        above_row !== '0 || left_col !== '0) begin
      fails++;
      $display("FAIL midload_reset: busy=%0b rdy=%0b ev=%0b above=%h left=%h, want all 0",
               busy, s_ready, edge_valid, above_row, left_col);
    end
    @(negedge clk);
    rst = 1'b0;
    do_block(1'b1, 1'b1, 30, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++)
      do_block(1'($urandom), 1'($urandom), $urandom_range(0, 50), $urandom_range(0, 4), 0);
  endtask

  initial begin
    test_reset();
    do_block(1'b1, 1'b1, 0, 0, 1);    // both sides, ramp data
    do_block(1'b0, 1'b1, 0, 0, 2);    // left only, above replicated from left[0]
    do_block(1'b0, 1'b0, 0, 0, 0);    // neither side
    do_block(1'b1, 1'b0, 0, 0, 0);    // above only
    do_block(1'b1, 1'b1, 40, 5, 0);   // gaps plus held edge_ready
    test_reset_midload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
